// File: rtl/freq_meas_sequencer.sv
// Measurement sequencer for the dual-channel reciprocal frequency counter:
// offset calibration, threshold setup, counter arm, settled-result capture.
module freq_meas_sequencer #(
  parameter int ADC_WIDTH        = 14,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int COUNT_WIDTH      = 32,
  parameter int CAL_LOG2         = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [15:0]                 hyst,
  input  logic [4:0]                  ncycles_log2,
  input  logic [COUNT_WIDTH-1:0]      timeout,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic [COUNT_WIDTH-1:0]      fc_counter_output,
  input  logic [COUNT_WIDTH-1:0]      fc_counter_outputI,
  input  logic [COUNT_WIDTH-1:0]      fc_count_ph_out,
  output logic                        fc_rst_n,
  output logic [COUNT_WIDTH-1:0]      fc_ncycles,
  output logic [COUNT_WIDTH-1:0]      fc_hi_ch1,
  output logic [COUNT_WIDTH-1:0]      fc_lo_ch1,
  output logic [COUNT_WIDTH-1:0]      fc_hi_ch2,
  output logic [COUNT_WIDTH-1:0]      fc_lo_ch2,
  output logic [COUNT_WIDTH-1:0]      offset_ch1,
  output logic [COUNT_WIDTH-1:0]      offset_ch2,
  output logic [COUNT_WIDTH-1:0]      freq_ch1,
  output logic [COUNT_WIDTH-1:0]      freq_ch2,
  output logic [COUNT_WIDTH-1:0]      phase,
  output logic                        busy,
  output logic                        done,
  output logic                        timeout_err
);

  localparam int CW   = COUNT_WIDTH;
  localparam int AW   = ADC_WIDTH + CAL_LOG2 + 1;
  localparam int HALF = AXIS_TDATA_WIDTH / 2;

  typedef enum logic [2:0] {
    S_IDLE, S_CAL, S_SET, S_ARM, S_WAIT, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic signed [AW-1:0]   acc1_q, acc1_d, acc2_q, acc2_d;
  logic [CAL_LOG2-1:0]    scnt_q, scnt_d;
  logic [15:0]            hyst_q, hyst_d;
  logic [4:0]             nlog_q, nlog_d;
  logic                   arm_q, arm_d;
  logic [CW-1:0]          tcnt_q, tcnt_d;
  logic [1:0]             upd1_q, upd1_d, upd2_q, upd2_d;
  logic [CW-1:0]          prev1_q, prev1_d, prev2_q, prev2_d;
  logic                   fc_rst_n_q, fc_rst_n_d;
  logic [CW-1:0]          ncyc_q, ncyc_d;
  logic [CW-1:0]          hi1_q, hi1_d, lo1_q, lo1_d;
  logic [CW-1:0]          hi2_q, hi2_d, lo2_q, lo2_d;
  logic [CW-1:0]          off1_q, off1_d, off2_q, off2_d;
  logic [CW-1:0]          freq1_q, freq1_d, freq2_q, freq2_d;
  logic [CW-1:0]          phase_q, phase_d;
  logic                   terr_q, terr_d;

  logic signed [ADC_WIDTH-1:0] s1, s2;
  logic signed [AW-1:0]        sh1, sh2;
  logic [CW-1:0]               off1, off2;

  // Stream bits outside the two sample fields are don't-care.
  logic unused_bits;
  assign unused_bits = ^{s_axis_tdata[HALF-1:ADC_WIDTH],
                         s_axis_tdata[AXIS_TDATA_WIDTH-1:HALF+ADC_WIDTH]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      acc1_q     <= '0;
      acc2_q     <= '0;
      scnt_q     <= '0;
      hyst_q     <= '0;
      nlog_q     <= '0;
      arm_q      <= 1'b0;
      tcnt_q     <= '0;
      upd1_q     <= '0;
      upd2_q     <= '0;
      prev1_q    <= '0;
      prev2_q    <= '0;
      fc_rst_n_q <= 1'b0;
      ncyc_q     <= '0;
      hi1_q      <= '0;
      lo1_q      <= '0;
      hi2_q      <= '0;
      lo2_q      <= '0;
      off1_q     <= '0;
      off2_q     <= '0;
      freq1_q    <= '0;
      freq2_q    <= '0;
      phase_q    <= '0;
      terr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc1_q     <= acc1_d;
      acc2_q     <= acc2_d;
      scnt_q     <= scnt_d;
      hyst_q     <= hyst_d;
      nlog_q     <= nlog_d;
      arm_q      <= arm_d;
      tcnt_q     <= tcnt_d;
      upd1_q     <= upd1_d;
      upd2_q     <= upd2_d;
      prev1_q    <= prev1_d;
      prev2_q    <= prev2_d;
      fc_rst_n_q <= fc_rst_n_d;
      ncyc_q     <= ncyc_d;
      hi1_q      <= hi1_d;
      lo1_q      <= lo1_d;
      hi2_q      <= hi2_d;
      lo2_q      <= lo2_d;
      off1_q     <= off1_d;
      off2_q     <= off2_d;
      freq1_q    <= freq1_d;
      freq2_q    <= freq2_d;
      phase_q    <= phase_d;
      terr_q     <= terr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    acc1_d     = acc1_q;
    acc2_d     = acc2_q;
    scnt_d     = scnt_q;
    hyst_d     = hyst_q;
    nlog_d     = nlog_q;
    arm_d      = arm_q;
    tcnt_d     = tcnt_q;
    upd1_d     = upd1_q;
    upd2_d     = upd2_q;
    prev1_d    = fc_counter_output;
    prev2_d    = fc_counter_outputI;
    fc_rst_n_d = fc_rst_n_q;
    ncyc_d     = ncyc_q;
    hi1_d      = hi1_q;
    lo1_d      = lo1_q;
    hi2_d      = hi2_q;
    lo2_d      = lo2_q;
    off1_d     = off1_q;
    off2_d     = off2_q;
    freq1_d    = freq1_q;
    freq2_d    = freq2_q;
    phase_d    = phase_q;
    terr_d     = terr_q;

    s1   = s_axis_tdata[ADC_WIDTH-1:0];
    s2   = s_axis_tdata[HALF+ADC_WIDTH-1:HALF];
    sh1  = acc1_q >>> CAL_LOG2;
    sh2  = acc2_q >>> CAL_LOG2;
    off1 = CW'(sh1);
    off2 = CW'(sh2);

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CAL;
          acc1_d  = '0;
          acc2_d  = '0;
          scnt_d  = '0;
          upd1_d  = '0;
          upd2_d  = '0;
          terr_d  = 1'b0;
          hyst_d  = hyst;
          nlog_d  = ncycles_log2;
        end
      end
      S_CAL: begin
        if (s_axis_tvalid) begin
          acc1_d = acc1_q + AW'(s1);
          acc2_d = acc2_q + AW'(s2);
          scnt_d = scnt_q + 1'b1;
          if (scnt_q == '1) state_d = S_SET;
        end
      end
      S_SET: begin
        off1_d     = off1;
        off2_d     = off2;
        hi1_d      = off1 + CW'(hyst_q);
        lo1_d      = off1 - CW'(hyst_q);
        hi2_d      = off2 + CW'(hyst_q);
        lo2_d      = off2 - CW'(hyst_q);
        ncyc_d     = CW'(nlog_q);
        fc_rst_n_d = 1'b0;
        arm_d      = 1'b0;
        state_d    = S_ARM;
      end
      S_ARM: begin
        if (arm_q) begin
          fc_rst_n_d = 1'b1;
          tcnt_d     = '0;
          state_d    = S_WAIT;
        end else begin
          arm_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (fc_counter_output != prev1_q && upd1_q != 2'd2)
          upd1_d = upd1_q + 2'd1;
        if (fc_counter_outputI != prev2_q && upd2_q != 2'd2)
          upd2_d = upd2_q + 2'd1;
        tcnt_d = tcnt_q + 1'b1;
        // Second update is the first one not averaged against a zero period.
        if (upd1_d == 2'd2 && upd2_d == 2'd2) begin
          freq1_d = fc_counter_output;
          freq2_d = fc_counter_outputI;
          phase_d = fc_count_ph_out;
          state_d = S_DONE;
        end else if (timeout != '0 && tcnt_d == timeout) begin
          terr_d  = 1'b1;
          freq1_d = fc_counter_output;
          freq2_d = fc_counter_outputI;
          phase_d = fc_count_ph_out;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign fc_rst_n    = fc_rst_n_q;
  assign fc_ncycles  = ncyc_q;
  assign fc_hi_ch1   = hi1_q;
  assign fc_lo_ch1   = lo1_q;
  assign fc_hi_ch2   = hi2_q;
  assign fc_lo_ch2   = lo2_q;
  assign offset_ch1  = off1_q;
  assign offset_ch2  = off2_q;
  assign freq_ch1    = freq1_q;
  assign freq_ch2    = freq2_q;
  assign phase       = phase_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_freq_meas_sequencer.sv
// Directed bench for freq_meas_sequencer with a 16-sample calibration
// and a hand-driven frequency-counter model.
module tb_freq_meas_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] hyst = '0;
  logic [4:0]  ncycles_log2 = '0;
  logic [31:0] timeout = '0;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic [31:0] fc1 = '0, fc2 = '0, fph = '0;
  logic        fc_rst_n;
  logic [31:0] fc_ncycles, fc_hi_ch1, fc_lo_ch1, fc_hi_ch2, fc_lo_ch2;
  logic [31:0] offset_ch1, offset_ch2, freq_ch1, freq_ch2, phase;
  logic        busy, done, timeout_err;

  int vectors = 0;
  int miscompares = 0;

  freq_meas_sequencer #(
    .ADC_WIDTH(14), .AXIS_TDATA_WIDTH(32),
    .COUNT_WIDTH(32), .CAL_LOG2(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .hyst(hyst),
    .ncycles_log2(ncycles_log2), .timeout(timeout),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
    .fc_counter_output(fc1), .fc_counter_outputI(fc2),
    .fc_count_ph_out(fph), .fc_rst_n(fc_rst_n),
    .fc_ncycles(fc_ncycles),
    .fc_hi_ch1(fc_hi_ch1), .fc_lo_ch1(fc_lo_ch1),
    .fc_hi_ch2(fc_hi_ch2), .fc_lo_ch2(fc_lo_ch2),
    .offset_ch1(offset_ch1), .offset_ch2(offset_ch2),
    .freq_ch1(freq_ch1), .freq_ch2(freq_ch2), .phase(phase),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #4 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int c1, input int c2);
    tdata  = {2'b00, c2[13:0], 2'b00, c1[13:0]};
    tvalid = 1'b1;
    tick();
    tvalid = 1'b0;
  endtask

  task automatic abort;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) tick();
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || fc_rst_n !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_ctrl got busy=%b done=%b fc_rst_n=%b want 0 0 0",
               busy, done, fc_rst_n);
    end
    vectors++;
    if ({offset_ch1, fc_hi_ch1, freq_ch1, phase, fc_ncycles} !== '0
        || timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_regs got off1=%0d hi1=%0d f1=%0d ph=%0d terr=%b want 0",
               offset_ch1, fc_hi_ch1, freq_ch1, phase, timeout_err);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_cal_offset;
    hyst = 16'd1;
    ncycles_log2 = 5'd5;
    pulse_start();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL cal_busy got %b want 1", busy);
    end
    hyst = 16'd9;
    ncycles_log2 = 5'd3;
    repeat (16) feed(-123, -23);
    tick();
    vectors++;
    if (offset_ch1 !== -32'sd123 || fc_hi_ch1 !== -32'sd122
        || fc_lo_ch1 !== -32'sd124) begin
      miscompares++;
      $display("FAIL cal_ch1 got %0d/%0d/%0d want -123/-122/-124",
               $signed(offset_ch1), $signed(fc_hi_ch1), $signed(fc_lo_ch1));
    end
    vectors++;
    if (offset_ch2 !== -32'sd23 || fc_hi_ch2 !== -32'sd22
        || fc_lo_ch2 !== -32'sd24) begin
      miscompares++;
      $display("FAIL cal_ch2 got %0d/%0d/%0d want -23/-22/-24",
               $signed(offset_ch2), $signed(fc_hi_ch2), $signed(fc_lo_ch2));
    end
    vectors++;
    if (fc_ncycles !== 32'd5 || fc_rst_n !== 1'b0) begin
      miscompares++;
      $display("FAIL cal_ncyc got ncyc=%0d fc_rst_n=%b want 5 0",
               fc_ncycles, fc_rst_n);
    end
    abort();
  endtask

  task automatic test_cal_floor;
    hyst = 16'd0;
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) feed(-5, 7);
      else feed(-6, 8);
    end
    tick();
    vectors++;
    if (offset_ch1 !== -32'sd6 || fc_hi_ch1 !== -32'sd6
        || fc_lo_ch1 !== -32'sd6) begin
      miscompares++;
      $display("FAIL floor_ch1 got %0d/%0d/%0d want -6/-6/-6",
               $signed(offset_ch1), $signed(fc_hi_ch1), $signed(fc_lo_ch1));
    end
    vectors++;
    if (offset_ch2 !== 32'd7) begin
      miscompares++;
      $display("FAIL floor_ch2 got %0d want 7", $signed(offset_ch2));
    end
    abort();
  endtask

  task automatic test_measure;
    hyst = 16'd2;
    timeout = 32'd0;
    pulse_start();
    repeat (16) feed(0, 0);
    tick();
    vectors++;
    if (offset_ch1 !== 32'd0 || fc_hi_ch1 !== 32'd2
        || fc_lo_ch1 !== -32'sd2) begin
      miscompares++;
      $display("FAIL meas_thr got %0d/%0d/%0d want 0/2/-2",
               $signed(offset_ch1), $signed(fc_hi_ch1), $signed(fc_lo_ch1));
    end
    tick();
    vectors++;
    if (fc_rst_n !== 1'b0) begin
      miscompares++;
      $display("FAIL meas_arm2 got fc_rst_n=%b want 0", fc_rst_n);
    end
    tick();
    vectors++;
    if (fc_rst_n !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL meas_wait got fc_rst_n=%b busy=%b want 1 1",
               fc_rst_n, busy);
    end
    fc1 = 32'd62;
    tick();
    tick();
    fc2 = 32'd60;
    tick();
    fc1 = 32'd125;
    tick();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL meas_early got done=%b want 0", done);
    end
    fc2 = 32'd124;
    fph = 32'd31;
    tick();
    vectors++;
    if (done !== 1'b1 || freq_ch1 !== 32'd125 || freq_ch2 !== 32'd124
        || phase !== 32'd31 || timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL meas_done got done=%b f1=%0d f2=%0d ph=%0d terr=%b want 1 125 124 31 0",
               done, freq_ch1, freq_ch2, phase, timeout_err);
    end
    tick();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || freq_ch1 !== 32'd125) begin
      miscompares++;
      $display("FAIL meas_idle got done=%b busy=%b f1=%0d want 0 0 125",
               done, busy, freq_ch1);
    end
  endtask

  task automatic test_timeout;
    int n;
    timeout = 32'd1000;
    hyst = 16'd0;
    pulse_start();
    repeat (16) feed(0, 0);
    vectors++;
    if (fc_rst_n !== 1'b1) begin
      miscompares++;
      $display("FAIL to_prearm got fc_rst_n=%b want 1", fc_rst_n);
    end
    tick();
    vectors++;
    if (fc_rst_n !== 1'b0) begin
      miscompares++;
      $display("FAIL to_arm got fc_rst_n=%b want 0", fc_rst_n);
    end
    tick();
    tick();
    n = 0;
    for (int i = 0; i < 1100; i++) begin
      if (i == 4) fc1 = 32'd200;
      if (i == 9) fc1 = 32'd250;
      tick();
      n++;
      if (done === 1'b1) break;
    end
    vectors++;
    if (n !== 1000 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL to_cycles got %0d done=%b want 1000 1", n, done);
    end
    vectors++;
    if (timeout_err !== 1'b1 || freq_ch1 !== 32'd250
        || freq_ch2 !== 32'd124 || phase !== 32'd31) begin
      miscompares++;
      $display("FAIL to_latch got terr=%b f1=%0d f2=%0d ph=%0d want 1 250 124 31",
               timeout_err, freq_ch1, freq_ch2, phase);
    end
    repeat (3) tick();
    vectors++;
    if (timeout_err !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL to_sticky got terr=%b busy=%b want 1 0",
               timeout_err, busy);
    end
  endtask

  task automatic test_ignored_start;
    int dones;
    timeout = 32'd0;
    pulse_start();
    vectors++;
    if (timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL ign_terrclr got %b want 0", timeout_err);
    end
    repeat (8) feed(100, -100);
    tdata = 32'h1fff_1fff;
    for (int i = 0; i < 50; i++) begin
      start = (i == 25);
      tick();
    end
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || fc_rst_n !== 1'b1) begin
      miscompares++;
      $display("FAIL ign_stall got busy=%b fc_rst_n=%b want 1 1",
               busy, fc_rst_n);
    end
    repeat (8) feed(100, -100);
    vectors++;
    if (fc_rst_n !== 1'b1) begin
      miscompares++;
      $display("FAIL ign_count got fc_rst_n=%b want 1", fc_rst_n);
    end
    tick();
    vectors++;
    if (fc_rst_n !== 1'b0 || offset_ch1 !== 32'd100
        || offset_ch2 !== -32'sd100) begin
      miscompares++;
      $display("FAIL ign_off got fc_rst_n=%b off1=%0d off2=%0d want 0 100 -100",
               fc_rst_n, $signed(offset_ch1), $signed(offset_ch2));
    end
    tick();
    tick();
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      start = (i == 10);
      tick();
      if (done === 1'b1) dones++;
    end
    start = 1'b0;
    vectors++;
    if (busy !== 1'b1 || dones !== 0) begin
      miscompares++;
      $display("FAIL ign_notimeout got busy=%b dones=%0d want 1 0",
               busy, dones);
    end
    fc1 = 32'd10;
    fc2 = 32'd10;
    tick();
    if (done === 1'b1) dones++;
    fc1 = 32'd20;
    fc2 = 32'd20;
    fph = 32'd7;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done === 1'b1) dones++;
    end
    vectors++;
    if (dones !== 1 || busy !== 1'b0 || freq_ch1 !== 32'd20
        || phase !== 32'd7) begin
      miscompares++;
      $display("FAIL ign_single got dones=%0d busy=%b f1=%0d ph=%0d want 1 0 20 7",
               dones, busy, freq_ch1, phase);
    end
  endtask

  task automatic test_reset_mid;
    int dones;
    hyst = 16'd3;
    ncycles_log2 = 5'd4;
    pulse_start();
    repeat (16) feed(50, -50);
    repeat (3) tick();
    vectors++;
    if (offset_ch1 !== 32'd50 || fc_rst_n !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_pre got off1=%0d fc_rst_n=%b busy=%b want 50 1 1",
               offset_ch1, fc_rst_n, busy);
    end
    fc1 = 32'd30;
    tick();
    rst = 1'b0;
    fc2 = 32'd33;
    tick();
    vectors++;
    if (busy !== 1'b0 || fc_rst_n !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_ctrl got busy=%b fc_rst_n=%b done=%b want 0 0 0",
               busy, fc_rst_n, done);
    end
    vectors++;
    if ({offset_ch1, offset_ch2, fc_hi_ch1, fc_lo_ch2, freq_ch1, freq_ch2,
         phase, fc_ncycles} !== '0 || timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_regs got off1=%0d lo2=%0d f1=%0d ph=%0d ncyc=%0d want 0",
               offset_ch1, fc_lo_ch2, freq_ch1, phase, fc_ncycles);
    end
    rst = 1'b1;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) fc1 = 32'd40;
      if (i == 4) fc2 = 32'd44;
      tick();
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    vectors++;
    if (dones !== 0) begin
      miscompares++;
      $display("FAIL mid_nodone got %0d active cycles want 0", dones);
    end
  endtask

  initial begin
    test_reset();
    test_cal_offset();
    test_cal_floor();
    test_measure();
    test_timeout();
    test_ignored_start();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
